mem_stage_access: RTL
=====================

Name: mem_stage_access

Overview:
- Consumer end of the EX/MEM pipeline register in the MIPS pipelined processor.
- Takes the registered MEM-stage fields and performs data-memory loads/stores over a req/ack handshake to a variable-latency data memory.
- Stalls the upstream pipeline while an access is outstanding.
- Drives the MEM/WB pipeline register outputs (with bubbles inserted while stalled).

Parameters:
- DMEM_AW, 30: word-address width to data memory; dmem_addr = alu_result_m[DMEM_AW+1:2].
- TIMEOUT_CYCLES, 255: cycles spent in REQ without ack before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- alu_result_m  input  32  ALU result / byte address from EX/MEM
- din_m  input  32  store data from EX/MEM
- rd_or_rt_m  input  5  destination register from EX/MEM
- reg_write_m  input  1  register-write control from EX/MEM
- mem_to_reg_m  input  1  load indicator from EX/MEM
- mem_write_m  input  1  store indicator from EX/MEM
- dmem_req  output  1  memory request, held until ack
- dmem_we  output  1  1 = store, 0 = load
- dmem_addr  output  DMEM_AW  word address
- dmem_wdata  output  32  store data
- dmem_ack  input  1  memory completion, one-cycle pulse
- dmem_rdata  input  32  load data, valid when dmem_ack = 1
- stall_m  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
- alu_result_w  output  32  MEM/WB ALU result
- read_data_w  output  32  MEM/WB load data
- rd_or_rt_w  output  5  MEM/WB destination register
- reg_write_w  output  1  MEM/WB register-write control
- mem_to_reg_w  output  1  MEM/WB load select
- mem_err  output  1  access-timeout pulse (0 unless MEM_TIMEOUT_EN)

Behaviour:
- mem_op = mem_write_m | mem_to_reg_m.
- If mem_write_m and mem_to_reg_m are both 1, the access is a store: dmem_we = 1, read_data_w loads 0.
- FSM states:
  - IDLE:
    - mem_op = 0: stall_m = 0; MEM/WB loads alu_result_m, rd_or_rt_m, reg_write_m, mem_to_reg_m = 0, read_data_w = 0. Latency 1 cycle.
    - mem_op = 1: stall_m = 1; MEM/WB loads a bubble (all fields 0); next state REQ.
  - REQ:
    - dmem_req = 1; dmem_we = mem_write_m; dmem_addr and dmem_wdata driven from EX/MEM fields, which are stable because stall_m = 1.
    - On dmem_ack: capture dmem_rdata into an internal hold register; next state RESP.
    - MEM/WB loads a bubble every cycle in this state.
  - RESP:
    - stall_m = 0; dmem_req = 0.
    - MEM/WB loads the EX/MEM fields; read_data_w = hold register for loads, 0 for stores.
    - Next state IDLE. EX/MEM advances at the end of this cycle.
- Minimum memory-op latency: 3 cycles (IDLE, REQ with same-cycle ack, RESP), i.e. 2 stall cycles.
- stall_m, dmem_req, dmem_we, dmem_addr and dmem_wdata are combinational from state and EX/MEM fields. dmem_we, dmem_addr and dmem_wdata are 0 outside REQ.
- dmem_ack is ignored in IDLE and RESP.
- Reset:
  - state = IDLE; all MEM/WB outputs = 0; hold register = 0; mem_err = 0; timeout counter = 0.
  - stall_m = 0 and dmem_req = 0 from the first cycle after the reset edge.
  - Reset during REQ abandons the access; a later ack is ignored.
- Address bits alu_result_m[1:0] are not checked; word access only.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES: dmem_req drops, next state RESP, hold register loads 32'hDEADBEEF, and mem_err = 1 for exactly the RESP cycle.
  - If ack and timeout occur in the same cycle, ack wins and mem_err stays 0.
- Undefined: no counter; mem_err tied 0; REQ waits indefinitely for ack.

Test Plan:
- ALU op (alu_result_m = 32'h0000_0010, rd_or_rt_m = 5, reg_write_m = 1, no mem_op) -> stall_m = 0; next cycle alu_result_w = 0x10, rd_or_rt_w = 5, reg_write_w = 1.
- Load at 0x0000_0040, memory acks on the 1st REQ cycle with 0x1234_5678 -> dmem_addr = 0x10, stall_m high 2 cycles, then read_data_w = 0x1234_5678, mem_to_reg_w = 1, and the bubble before it has reg_write_w = 0.
- Store at 0x0000_0008, din_m = 0xCAFE_F00D, ack after 4 cycles -> dmem_we = 1, dmem_wdata = 0xCAFE_F00D stable all 4 REQ cycles, stall_m high 5 cycles, read_data_w = 0.
- Back-to-back load then ALU op -> ALU op reaches WB one cycle after the load's RESP; no duplicate or dropped instruction.
- Reset asserted in the 2nd REQ cycle, ack pulsed the cycle after -> dmem_req = 0 and stall_m = 0 after the reset edge, MEM/WB all 0, ack ignored.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> dmem_req drops after 4 REQ cycles, read_data_w = 0xDEADBEEF, mem_err high for exactly 1 cycle.

Source files
------------

// File: rtl/mem_stage_access.sv
// mem_stage_access -- MEM stage of the pipelined MIPS core.
//
// Sits on the output of the EX/MEM register.  Non-memory instructions flow
// straight through to MEM/WB in one cycle.  Loads and stores hand one word
// access to a variable-latency data memory over a req/ack handshake.  The
// upstream pipeline is frozen (stall_m) until the access finishes.  MEM/WB
// gets bubbles while the stage is stalled.
//
// Optional build macro: MEM_TIMEOUT_EN -- abort an access that waits
// TIMEOUT_CYCLES cycles in REQ without ack.  The aborted access returns
// 32'hDEADBEEF and pulses mem_err.  With the macro undefined, REQ waits
// for ack indefinitely and mem_err is tied low.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   alu_result_m .. mem_write_m  EX/MEM fields (held stable while stall_m)
//   dmem_req/we/addr/wdata       request to data memory, held until ack
//   dmem_ack/rdata               one-cycle completion pulse and load data
//   stall_m                      freeze PC, IF/ID, ID/EX, EX/MEM
//   alu_result_w .. mem_to_reg_w MEM/WB register outputs
//   mem_err                      access-timeout pulse (RESP cycle only)
module mem_stage_access #(
  parameter int DMEM_AW        = 30,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        alu_result_m,
  input  logic [31:0]        din_m,
  input  logic [4:0]         rd_or_rt_m,
  input  logic               reg_write_m,
  input  logic               mem_to_reg_m,
  input  logic               mem_write_m,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
  output logic               stall_m,
  output logic [31:0]        alu_result_w,
  output logic [31:0]        read_data_w,
  output logic [4:0]         rd_or_rt_w,
  output logic               reg_write_w,
  output logic               mem_to_reg_w,
  output logic               mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] alu_result_w_q, alu_result_w_d;
  logic [31:0] read_data_w_q, read_data_w_d;
  logic [4:0]  rd_or_rt_w_q, rd_or_rt_w_d;
  logic        reg_write_w_q, reg_write_w_d;
  logic        mem_to_reg_w_q, mem_to_reg_w_d;

  logic mem_op, in_req, timeout;

  assign mem_op = mem_write_m | mem_to_reg_m;
  assign in_req = (state_q == S_REQ);

  // Request side is purely combinational from state and the EX/MEM fields;
  // the fields cannot move while we stall, so the request stays stable.
  // A store that also has mem_to_reg set is still a store.
  assign stall_m    = in_req | ((state_q == S_IDLE) & mem_op);
  assign dmem_req   = in_req;
  assign dmem_we    = in_req & mem_write_m;
  assign dmem_addr  = in_req ? alu_result_m[DMEM_AW+1:2] : '0;
  assign dmem_wdata = in_req ? din_m : '0;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;

  // Counter holds the number of ack-less REQ cycles already spent.  The
  // abort fires on the cycle that would make it reach TIMEOUT_CYCLES, so
  // the request is held for exactly TIMEOUT_CYCLES cycles.  An ack in that
  // same cycle wins.
  assign timeout = in_req & ~dmem_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d     = cnt_q;
    mem_err_d = timeout;
    if (state_q == S_IDLE)   cnt_d = '0;
    else if (in_req & ~dmem_ack) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    // Bubble unless an instruction retires from this stage this cycle.
    alu_result_w_d = '0;
    read_data_w_d  = '0;
    rd_or_rt_w_d   = '0;
    reg_write_w_d  = 1'b0;
    mem_to_reg_w_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          state_d = S_REQ;
        end else begin
          alu_result_w_d = alu_result_m;
          rd_or_rt_w_d   = rd_or_rt_m;
          reg_write_w_d  = reg_write_m;
        end
      end
      S_REQ: begin
        if (dmem_ack) begin
          hold_d  = dmem_rdata;
          state_d = S_RESP;
        end else if (timeout) begin
          hold_d  = 32'hDEAD_BEEF;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        alu_result_w_d = alu_result_m;
        rd_or_rt_w_d   = rd_or_rt_m;
        reg_write_w_d  = reg_write_m;
        mem_to_reg_w_d = mem_to_reg_m;
        read_data_w_d  = mem_write_m ? 32'h0 : hold_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      hold_q         <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      rd_or_rt_w_q   <= '0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      rd_or_rt_w_q   <= rd_or_rt_w_d;
      reg_write_w_q  <= reg_write_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
    end
  end

  assign alu_result_w = alu_result_w_q;
  assign read_data_w  = read_data_w_q;
  assign rd_or_rt_w   = rd_or_rt_w_q;
  assign reg_write_w  = reg_write_w_q;
  assign mem_to_reg_w = mem_to_reg_w_q;

endmodule
